// File: rtl/sad_mem_pipe_stage.sv
// Memory-to-SAD pipeline register: scalar payload plus a window and a frame vector bank
// with load flags, frame capture sequence count and a sticky overwrite error.
module sad_mem_pipe_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANES  = 16,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned SEQ_W  = 8
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      Stall,
   input  logic                      Flush,
   input  logic                      ValidM,
   input  logic [8:0]                CtrlM,
   input  logic [1:0]                SADM,
   input  logic [DATA_W-1:0]         MemReadDataM,
   input  logic [DATA_W-1:0]         ALUResultM,
   input  logic [DATA_W-1:0]         PCPlus4M,
   input  logic [DATA_W-1:0]         instructionM,
   input  logic [DATA_W-1:0]         FADM,
   input  logic [REG_W-1:0]          WriteRegM,
   input  logic [LANES*DATA_W-1:0]   VecM,
   input  logic                      Consume,
   output logic                      ValidS,
   output logic [8:0]                CtrlS,
   output logic [1:0]                SADS,
   output logic [DATA_W-1:0]         MemReadDataS,
   output logic [DATA_W-1:0]         ALUResultS,
   output logic [DATA_W-1:0]         PCPlus4S,
   output logic [DATA_W-1:0]         instructionS,
   output logic [DATA_W-1:0]         FADS,
   output logic [REG_W-1:0]          WriteRegS,
   output logic [LANES*DATA_W-1:0]   WinVecS,
   output logic [LANES*DATA_W-1:0]   FrmVecS,
   output logic                      WinLoaded,
   output logic                      FrmLoaded,
   output logic                      PairReady,
   output logic [SEQ_W-1:0]          FrmSeq,
   output logic                      OverwriteErr
);

   logic advance, capture, win_cap, frm_cap;

   logic                    valid_q;
   logic [8:0]              ctrl_q;
   logic [1:0]              sad_q;
   logic [DATA_W-1:0]       mem_rd_q, alu_q, pc4_q, instr_q, fad_q;
   logic [REG_W-1:0]        wreg_q;
   logic [LANES*DATA_W-1:0] win_q, frm_q;
   logic                    win_loaded_q, win_loaded_d;
   logic                    frm_loaded_q, frm_loaded_d;
   logic [SEQ_W-1:0]        frm_seq_q, frm_seq_d;
   logic                    overwrite_q, overwrite_d;

   assign advance = ~Stall & ~Flush;
   assign capture = advance & ValidM;
   assign win_cap = capture & (SADM == 2'd3);
   assign frm_cap = capture & ((SADM == 2'd1) | (SADM == 2'd2));

   // Flush wins over Stall; a bubble clears valid and control but still carries payload.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         sad_q    <= '0;
         mem_rd_q <= '0;
         alu_q    <= '0;
         pc4_q    <= '0;
         instr_q  <= '0;
         fad_q    <= '0;
         wreg_q   <= '0;
      end else if (Flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         sad_q   <= '0;
      end else if (!Stall) begin
         valid_q  <= ValidM;
         ctrl_q   <= ValidM ? CtrlM : '0;
         sad_q    <= SADM;
         mem_rd_q <= MemReadDataM;
         alu_q    <= ALUResultM;
         pc4_q    <= PCPlus4M;
         instr_q  <= instructionM;
         fad_q    <= FADM;
         wreg_q   <= WriteRegM;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         win_q <= '0;
         frm_q <= '0;
      end else begin
         if (win_cap) win_q <= VecM;
         if (frm_cap) frm_q <= VecM;
      end
   end

   // Consume acts even while stalled; a same-cycle capture keeps its own flag set.
   always_comb begin
      win_loaded_d = win_cap | (win_loaded_q & ~Consume);
      frm_loaded_d = frm_cap | (frm_loaded_q & ~Consume);
      frm_seq_d    = frm_cap ? frm_seq_q + SEQ_W'(1) : frm_seq_q;
      overwrite_d  = overwrite_q
                   | (win_cap & win_loaded_q & ~Consume)
                   | (frm_cap & frm_loaded_q & ~Consume);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         win_loaded_q <= 1'b0;
         frm_loaded_q <= 1'b0;
         frm_seq_q    <= '0;
         overwrite_q  <= 1'b0;
      end else begin
         win_loaded_q <= win_loaded_d;
         frm_loaded_q <= frm_loaded_d;
         frm_seq_q    <= frm_seq_d;
         overwrite_q  <= overwrite_d;
      end
   end

   assign ValidS       = valid_q;
   assign CtrlS        = ctrl_q;
   assign SADS         = sad_q;
   assign MemReadDataS = mem_rd_q;
   assign ALUResultS   = alu_q;
   assign PCPlus4S     = pc4_q;
   assign instructionS = instr_q;
   assign FADS         = fad_q;
   assign WriteRegS    = wreg_q;
   assign WinVecS      = win_q;
   assign FrmVecS      = frm_q;
   assign WinLoaded    = win_loaded_q;
   assign FrmLoaded    = frm_loaded_q;
   assign PairReady    = win_loaded_q & frm_loaded_q;
   assign FrmSeq       = frm_seq_q;
   assign OverwriteErr = overwrite_q;

endmodule

// File: tb/tb_sad_mem_pipe_stage.sv
// Randomized bench for sad_mem_pipe_stage against a per-cycle behavioural model of the
// stage's register, bank, flag and counter rules.
module tb_sad_mem_pipe_stage;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 16;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned SEQ_W  = 8;
   localparam int unsigned VW     = LANES * DATA_W;

   logic              Clk, Reset_n, Stall, Flush, ValidM, Consume;
   logic [8:0]        CtrlM, CtrlS;
   logic [1:0]        SADM, SADS;
   logic [DATA_W-1:0] MemReadDataM, ALUResultM, PCPlus4M, instructionM, FADM;
   logic [DATA_W-1:0] MemReadDataS, ALUResultS, PCPlus4S, instructionS, FADS;
   logic [REG_W-1:0]  WriteRegM, WriteRegS;
   logic [VW-1:0]     VecM, WinVecS, FrmVecS;
   logic              ValidS, WinLoaded, FrmLoaded, PairReady, OverwriteErr;
   logic [SEQ_W-1:0]  FrmSeq;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic              m_valid;
   logic [8:0]        m_ctrl;
   logic [1:0]        m_sad;
   logic [DATA_W-1:0] m_rd, m_alu, m_pc4, m_instr, m_fad;
   logic [REG_W-1:0]  m_wreg;
   logic [VW-1:0]     m_win, m_frm;
   logic              m_wl, m_fl, m_err;
   int                m_seq;

   sad_mem_pipe_stage #(
      .DATA_W(DATA_W), .LANES(LANES), .REG_W(REG_W), .SEQ_W(SEQ_W)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush), .ValidM(ValidM),
      .CtrlM(CtrlM), .SADM(SADM), .MemReadDataM(MemReadDataM), .ALUResultM(ALUResultM),
      .PCPlus4M(PCPlus4M), .instructionM(instructionM), .FADM(FADM),
      .WriteRegM(WriteRegM), .VecM(VecM), .Consume(Consume),
      .ValidS(ValidS), .CtrlS(CtrlS), .SADS(SADS), .MemReadDataS(MemReadDataS),
      .ALUResultS(ALUResultS), .PCPlus4S(PCPlus4S), .instructionS(instructionS),
      .FADS(FADS), .WriteRegS(WriteRegS), .WinVecS(WinVecS), .FrmVecS(FrmVecS),
      .WinLoaded(WinLoaded), .FrmLoaded(FrmLoaded), .PairReady(PairReady),
      .FrmSeq(FrmSeq), .OverwriteErr(OverwriteErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic model_clear();
      m_valid = 0; m_ctrl = '0; m_sad = '0; m_rd = '0; m_alu = '0; m_pc4 = '0;
      m_instr = '0; m_fad = '0; m_wreg = '0; m_win = '0; m_frm = '0;
      m_wl = 0; m_fl = 0; m_err = 0; m_seq = 0;
   endtask

   // One clock of the stage described from its rules, using the inputs currently driven.
   task automatic model_step();
      logic adv, cap, wc, fc;
      adv = !Stall && !Flush;
      cap = adv && ValidM;
      wc  = cap && (SADM == 2'd3);
      fc  = cap && (SADM == 2'd1 || SADM == 2'd2);
      if (Flush) begin
         m_valid = 0; m_ctrl = '0; m_sad = '0;
      end else if (!Stall) begin
         m_valid = ValidM;
         m_ctrl  = ValidM ? CtrlM : 9'd0;
         m_sad   = SADM;
         m_rd = MemReadDataM; m_alu = ALUResultM; m_pc4 = PCPlus4M;
         m_instr = instructionM; m_fad = FADM; m_wreg = WriteRegM;
      end
      if (((wc && m_wl) || (fc && m_fl)) && !Consume) m_err = 1;
      if (Consume) begin m_wl = 0; m_fl = 0; end
      if (wc) begin m_win = VecM; m_wl = 1; end
      if (fc) begin m_frm = VecM; m_fl = 1; m_seq = (m_seq + 1) % (1 << SEQ_W); end
   endtask

   task automatic tick();
      model_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [1:0] sad, input logic cons,
                        input logic stall, input logic flush);
      logic [VW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DATA_W +: DATA_W] = $urandom | 32'd1;
      ValidM = valid; SADM = sad; Consume = cons; Stall = stall; Flush = flush;
      CtrlM = 9'($urandom) | 9'd1;
      MemReadDataM = $urandom | 32'd1; ALUResultM = $urandom | 32'd1;
      PCPlus4M = $urandom | 32'd1; instructionM = $urandom | 32'd1;
      FADM = $urandom | 32'd1; WriteRegM = 5'($urandom) | 5'd1;
      VecM = v;
   endtask

   task automatic pulse_reset();
      drive(0, 2'd0, 0, 0, 0);
      Reset_n = 0;
      #1;
      model_clear();
      Reset_n = 1;
   endtask

   task automatic test_reset();
      drive(0, 2'd0, 0, 0, 0);
      Reset_n = 0;
      model_clear();
      #2;
      checks++;
      if ({ValidS, CtrlS, SADS, WinLoaded, FrmLoaded, PairReady, FrmSeq, OverwriteErr} !== '0)
      begin
         errors++;
         $display("FAIL reset_init flags got=%h exp=0",
                  {ValidS, CtrlS, SADS, WinLoaded, FrmLoaded, PairReady, FrmSeq, OverwriteErr});
      end
      @(negedge Clk);
      Reset_n = 1;
      drive(1, 2'd3, 0, 0, 0); tick();
      drive(1, 2'd1, 0, 0, 0); tick();
      drive(1, 2'd3, 0, 0, 0); tick();
      checks++;
      if ({OverwriteErr, PairReady, ValidS, SADS} !== {m_err, m_wl & m_fl, m_valid, m_sad}) begin
         errors++;
         $display("FAIL reset_preload got=%b exp=%b", {OverwriteErr, PairReady, ValidS, SADS},
                  {m_err, m_wl & m_fl, m_valid, m_sad});
      end
      #3;
      Reset_n = 0;
      #1;
      model_clear();
      checks++;
      if ({ValidS, CtrlS, SADS, MemReadDataS, ALUResultS, PCPlus4S, instructionS, FADS,
           WriteRegS} !== '0) begin
         errors++;
         $display("FAIL async_reset_scalars got=%h exp=0", {ValidS, CtrlS, SADS, MemReadDataS,
                  ALUResultS, PCPlus4S, instructionS, FADS, WriteRegS});
      end
      checks++;
      if ({WinVecS, FrmVecS, WinLoaded, FrmLoaded, PairReady, FrmSeq, OverwriteErr} !== '0)
      begin
         errors++;
         $display("FAIL async_reset_banks got win=%h frm=%h flags=%b seq=%0d exp=0",
                  WinVecS, FrmVecS, {WinLoaded, FrmLoaded, PairReady, OverwriteErr}, FrmSeq);
      end
      // Capture presented while reset is held must be discarded.
      drive(1, 2'd3, 0, 0, 0);
      @(posedge Clk);
      #1;
      checks++;
      if (WinLoaded !== 1'b0 || ValidS !== 1'b0) begin
         errors++;
         $display("FAIL reset_held_capture got wl=%b v=%b exp wl=0 v=0", WinLoaded, ValidS);
      end
      Reset_n = 1;
      tick();
      checks++;
      if (WinLoaded !== 1'b1 || WinVecS !== m_win) begin
         errors++;
         $display("FAIL first_capture_after_reset got wl=%b exp wl=1", WinLoaded);
      end
   endtask

   task automatic test_win_capture();
      logic [VW-1:0] v;
      pulse_reset();
      for (int k = 0; k < LANES; k++) v[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
      drive(1, 2'd3, 0, 0, 0);
      VecM = v;
      tick();
      checks++;
      if (WinVecS[15*DATA_W +: DATA_W] !== 32'd16) begin
         errors++;
         $display("FAIL win_lane15 got=%0d exp=16", WinVecS[15*DATA_W +: DATA_W]);
      end
      checks++;
      if ({WinLoaded, FrmLoaded, FrmSeq} !== {1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL win_flags got wl=%b fl=%b seq=%0d exp wl=1 fl=0 seq=0",
                  WinLoaded, FrmLoaded, FrmSeq);
      end
      checks++;
      if (WinVecS !== m_win || ValidS !== 1'b1 || CtrlS !== m_ctrl || FADS !== m_fad) begin
         errors++;
         $display("FAIL win_payload got v=%b ctrl=%h fad=%h exp v=1 ctrl=%h fad=%h",
                  ValidS, CtrlS, FADS, m_ctrl, m_fad);
      end
   endtask

   task automatic test_frm_wrap();
      pulse_reset();
      for (int i = 0; i < 300 && m_seq != 255; i++) begin
         drive(1, 2'($urandom_range(1, 2)), 1, 0, 0);
         tick();
      end
      checks++;
      if (FrmSeq !== 8'd255 || OverwriteErr !== 1'b0) begin
         errors++;
         $display("FAIL frm_seq_255 got seq=%0d err=%b exp seq=255 err=0", FrmSeq, OverwriteErr);
      end
      drive(1, 2'd3, 1, 0, 0); tick();
      drive(1, 2'd2, 0, 0, 0); tick();
      checks++;
      if ({FrmSeq, FrmLoaded, PairReady, OverwriteErr} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL frm_wrap got seq=%0d fl=%b pr=%b err=%b exp seq=0 fl=1 pr=1 err=0",
                  FrmSeq, FrmLoaded, PairReady, OverwriteErr);
      end
      checks++;
      if (FrmVecS !== m_frm) begin
         errors++;
         $display("FAIL frm_wrap_data got=%h exp=%h", FrmVecS, m_frm);
      end
   endtask

   task automatic test_stall_flush();
      logic [VW-1:0] frm_exp;
      logic [SEQ_W-1:0] seq_exp;
      drive(1, 2'd1, 1, 0, 0); tick();
      frm_exp = m_frm;
      seq_exp = SEQ_W'(m_seq);
      drive(1, 2'd1, 0, 1, 1); tick();
      checks++;
      if (ValidS !== 1'b0 || CtrlS !== 9'd0) begin
         errors++;
         $display("FAIL stall_flush_bubble got v=%b ctrl=%h exp v=0 ctrl=0", ValidS, CtrlS);
      end
      checks++;
      if (FrmVecS !== frm_exp || FrmSeq !== seq_exp) begin
         errors++;
         $display("FAIL stall_flush_hold got seq=%0d exp seq=%0d", FrmSeq, seq_exp);
      end
   endtask

   task automatic test_consume_capture();
      logic err_exp;
      drive(1, 2'd3, 1, 0, 0); tick();
      drive(1, 2'd1, 0, 0, 0); tick();
      checks++;
      if (PairReady !== 1'b1) begin
         errors++;
         $display("FAIL consume_setup got pr=%b exp pr=1", PairReady);
      end
      err_exp = m_err;
      drive(1, 2'd3, 1, 0, 0); tick();
      checks++;
      if ({WinLoaded, FrmLoaded, OverwriteErr} !== {1'b1, 1'b0, err_exp}) begin
         errors++;
         $display("FAIL consume_capture got wl=%b fl=%b err=%b exp wl=1 fl=0 err=%b",
                  WinLoaded, FrmLoaded, OverwriteErr, err_exp);
      end
      // Consume while stalled still clears the flags.
      drive(0, 2'd0, 1, 1, 0); tick();
      checks++;
      if ({WinLoaded, FrmLoaded} !== 2'b00) begin
         errors++;
         $display("FAIL consume_in_stall got wl=%b fl=%b exp 0 0", WinLoaded, FrmLoaded);
      end
   endtask

   task automatic test_overwrite();
      pulse_reset();
      drive(1, 2'd3, 0, 0, 0); tick();
      drive(1, 2'd3, 0, 0, 0); tick();
      checks++;
      if (OverwriteErr !== 1'b1) begin
         errors++;
         $display("FAIL overwrite_set got=%b exp=1", OverwriteErr);
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'($urandom), 2'($urandom), 1, 1'($urandom), 1'($urandom));
         tick();
      end
      checks++;
      if (OverwriteErr !== 1'b1) begin
         errors++;
         $display("FAIL overwrite_sticky got=%b exp=1", OverwriteErr);
      end
      #2;
      Reset_n = 0;
      #1;
      model_clear();
      checks++;
      if (OverwriteErr !== 1'b0) begin
         errors++;
         $display("FAIL overwrite_reset got=%b exp=0", OverwriteErr);
      end
      Reset_n = 1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
         tick();
         checks++;
         if ({ValidS, CtrlS, SADS, WriteRegS} !== {m_valid, m_ctrl, m_sad, m_wreg}) begin
            errors++;
            $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", i,
                     {ValidS, CtrlS, SADS, WriteRegS}, {m_valid, m_ctrl, m_sad, m_wreg});
         end
         checks++;
         if ({MemReadDataS, ALUResultS, PCPlus4S, instructionS, FADS}
             !== {m_rd, m_alu, m_pc4, m_instr, m_fad}) begin
            errors++;
            $display("FAIL rand_payload cyc=%0d got=%h exp=%h", i,
                     {MemReadDataS, ALUResultS, PCPlus4S, instructionS, FADS},
                     {m_rd, m_alu, m_pc4, m_instr, m_fad});
         end
         checks++;
         if (WinVecS !== m_win || FrmVecS !== m_frm) begin
            errors++;
            $display("FAIL rand_banks cyc=%0d win_ok=%b frm_ok=%b", i,
                     WinVecS === m_win, FrmVecS === m_frm);
         end
         checks++;
         if ({WinLoaded, FrmLoaded, PairReady, FrmSeq, OverwriteErr}
             !== {m_wl, m_fl, m_wl & m_fl, SEQ_W'(m_seq), m_err}) begin
            errors++;
            $display("FAIL rand_flags cyc=%0d got wl=%b fl=%b pr=%b seq=%0d err=%b exp wl=%b fl=%b seq=%0d err=%b",
                     i, WinLoaded, FrmLoaded, PairReady, FrmSeq, OverwriteErr,
                     m_wl, m_fl, m_seq, m_err);
         end
      end
   endtask

   initial begin
      Reset_n = 0;
      test_reset();
      test_win_capture();
      test_frm_wrap();
      test_stall_flush();
      test_consume_capture();
      test_overwrite();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sad_mem_pipe_stage.md
SAD_MEM_PIPE_STAGE -- requirements
Module: sad_mem_pipe_stage

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- DATA_W  32  width of every data word and vector lane
- LANES  16  number of vector lanes per bank
- REG_W  5  destination register index width
- SEQ_W  8  frame-capture sequence counter width
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning.
- Clk  in  1  single clock; all state updates on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Stall  in  1  hold all stage state
- Flush  in  1  insert bubble
- ValidM  in  1  upstream stage holds a real instruction
- CtrlM  in  9  {MemtoReg, RegWrite, jal, Display, BranchType[1:0], hazardType, Branch, spare}
- SADM  in  2  vector mode: 0 none, 1/2 frame, 3 window
- MemReadDataM, ALUResultM, PCPlus4M, instructionM, FADM  in  DATA_W each  scalar payload
- WriteRegM  in  REG_W  destination register
- VecM  in  LANES*DATA_W  vector lanes, lane 0 in LSBs
- Consume  in  1  downstream has used both banks
- ValidS, CtrlS, SADS, MemReadDataS, ALUResultS, PCPlus4S, instructionS, FADS, WriteRegS  out  as inputs  registered copies
- WinVecS, FrmVecS  out  LANES*DATA_W  window bank, frame bank
- WinLoaded, FrmLoaded  out  1  bank holds data not yet consumed
- PairReady  out  1  both banks loaded
- FrmSeq  out  SEQ_W  count of frame captures
- OverwriteErr  out  1  sticky: a loaded bank was overwritten before Consume

Function
REQ-003 Advance = ~Stall & ~Flush; on Advance every scalar output SHALL load its M input on the rising edge (latency 1 cycle).
REQ-004 Flush SHALL take priority over Stall; on Flush ValidS, CtrlS and SADS SHALL become 0; other scalar outputs are don't-care but SHALL hold.
REQ-005 On Stall without Flush every register, bank, flag and counter SHALL hold.
REQ-006 Capture = Advance & ValidM; with ValidM=0, Advance SHALL load ValidS=0 and CtrlS=0 (bubble), and no bank SHALL be written.
REQ-007 Capture & SADM==3 SHALL load WinVecS<=VecM and set WinLoaded; FrmVecS SHALL hold.
REQ-008 Capture & SADM in {1,2} SHALL load FrmVecS<=VecM, set FrmLoaded, and increment FrmSeq modulo 2^SEQ_W (wrap 2^SEQ_W-1 -> 0).
REQ-009 Capture & SADM==0 SHALL leave both banks, flags and FrmSeq unchanged.
REQ-010 PairReady SHALL equal WinLoaded & FrmLoaded (combinational from registered flags).
REQ-011 Consume (not gated by Stall) SHALL clear WinLoaded and FrmLoaded; bank contents SHALL hold.
REQ-012 Consume in the same cycle as a capture SHALL clear the non-captured flag and leave the captured bank's flag set.
REQ-013 A capture into a bank whose flag is already set and not cleared by Consume that cycle SHALL set OverwriteErr; only reset clears it.
REQ-014 Implementation SHALL be a single stage: no combinational path from any M input to any S output.

Reset
REQ-015 Reset_n low SHALL immediately, without a clock, force every output, bank, flag, FrmSeq and OverwriteErr to 0.
REQ-016 Reset asserted mid-capture SHALL discard that capture; first capture possible on the first rising edge after Reset_n is sampled high.

Verification
REQ-017 Bench SHALL cover:
- Reset_n=0 asynchronously between edges with all outputs nonzero -> every output 0 before the next edge.
- ValidM=1, SADM=3, VecM lane k = k+1, Advance -> next cycle WinVecS lane 15 = 16, WinLoaded=1, FrmLoaded=0, FrmSeq=0.
- Frame capture at FrmSeq=2^SEQ_W-1 (255) -> FrmSeq=0, FrmLoaded=1; PairReady=1 if window already loaded.
- Stall=1 and Flush=1 together with ValidM=1, SADM=1 -> ValidS=0, CtrlS=0, FrmVecS and FrmSeq unchanged.
- Consume plus window capture in one cycle with both flags set -> WinLoaded=1, FrmLoaded=0, OverwriteErr unchanged.
- Two window captures without Consume -> OverwriteErr=1, held until Reset_n=0.
